// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcode/func
// fields, ALU operation codes and the decoded instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] aluc;
    logic       shift;
    logic       sext;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/func to instruction class, ALU op,
// shift-amount select and immediate sign-extension for the EXE step.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.cls   = C_ILL;
    o_dec.aluc  = ALU_ADD;
    o_dec.shift = 1'b0;
    o_dec.sext  = 1'b0;
    case (i_op)
      OP_R: begin
        case (i_func)
          FN_ADD: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_ADD; end
          FN_SUB: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_SUB; end
          FN_AND: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_AND; end
          FN_OR:  begin o_dec.cls = C_RALU; o_dec.aluc = ALU_OR;  end
          FN_XOR: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_XOR; end
          FN_SLL: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_SLL; o_dec.shift = 1'b1; end
          FN_SRL: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_SRL; o_dec.shift = 1'b1; end
          FN_SRA: begin o_dec.cls = C_RALU; o_dec.aluc = ALU_SRA; o_dec.shift = 1'b1; end
          FN_JR:  o_dec.cls = C_JR;
          default: ;
        endcase
      end
      OP_ADDI: begin o_dec.cls = C_IALU; o_dec.aluc = ALU_ADD; o_dec.sext = 1'b1; end
      OP_ANDI: begin o_dec.cls = C_IALU; o_dec.aluc = ALU_AND; end
      OP_ORI:  begin o_dec.cls = C_IALU; o_dec.aluc = ALU_OR;  end
      OP_XORI: begin o_dec.cls = C_IALU; o_dec.aluc = ALU_XOR; end
      OP_LUI:  begin o_dec.cls = C_IALU; o_dec.aluc = ALU_LUI; end
      OP_LW:   begin o_dec.cls = C_LW;   o_dec.sext = 1'b1; end
      OP_SW:   begin o_dec.cls = C_SW;   o_dec.sext = 1'b1; end
      OP_BEQ:  begin o_dec.cls = C_BEQ;  o_dec.aluc = ALU_SUB; end
      OP_BNE:  begin o_dec.cls = C_BNE;  o_dec.aluc = ALU_SUB; end
      OP_J:    o_dec.cls = C_J;
      OP_JAL:  o_dec.cls = C_JAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB). Optional performance counters
// cyc_cnt/instret are compiled in when MC_CTRL_PERF_EN is defined.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] RST_PC_SEL = 2'b00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        wmem,
  output logic        iord,
  output logic        wpc,
  output logic        wir,
  output logic        wreg,
  output logic        regrt,
  output logic        m2reg,
  output logic        jal,
  output logic        sext,
  output logic        shift,
  output logic [1:0]  alusrcb,
  output logic [3:0]  aluc,
  output logic [1:0]  pcsource,
  output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instret
`endif
);

  state_t r_state;
  state_t w_next;
  dec_t   w_dec;
  logic   w_taken;

  mc_decode u_decode (
    .i_op   (op),
    .i_func (func),
    .o_dec  (w_dec)
  );

  assign w_taken = ((w_dec.cls == C_BEQ) &  zero) |
                   ((w_dec.cls == C_BNE) & ~zero);
  assign state   = r_state;

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = mem_rdy ? S_ID : S_IF;
      S_ID: begin
        case (w_dec.cls)
          C_J, C_JAL, C_JR, C_ILL: w_next = S_IF;
          default:                 w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        case (w_dec.cls)
          C_LW, C_SW:   w_next = S_MEM;
          C_BEQ, C_BNE: w_next = S_IF;
          default:      w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (!mem_rdy)                w_next = S_MEM;
        else if (w_dec.cls == C_LW)  w_next = S_WB;
        else                         w_next = S_IF;
      end
      S_WB:    w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    mem_req  = 1'b0;
    wmem     = 1'b0;
    iord     = 1'b0;
    wpc      = 1'b0;
    wir      = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    alusrcb  = 2'b00;
    aluc     = ALU_ADD;
    pcsource = 2'b00;
    case (r_state)
      S_IF: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        wir     = mem_rdy;
        wpc     = mem_rdy;
      end
      S_ID: begin
        // ALU precomputes PC+4 + (imm<<2) so EXE can redirect on a branch.
        alusrcb = 2'b11;
        sext    = 1'b1;
        case (w_dec.cls)
          C_J:   begin wpc = 1'b1; pcsource = 2'b11; end
          C_JAL: begin wpc = 1'b1; pcsource = 2'b11; wreg = 1'b1; jal = 1'b1; end
          C_JR:  begin wpc = 1'b1; pcsource = 2'b10; end
          default: ;
        endcase
      end
      S_EXE: begin
        aluc = w_dec.aluc;
        sext = w_dec.sext;
        case (w_dec.cls)
          C_RALU:             shift = w_dec.shift;
          C_IALU, C_LW, C_SW: alusrcb = 2'b10;
          C_BEQ, C_BNE: begin
            wpc      = w_taken;
            pcsource = w_taken ? 2'b01 : 2'b00;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        wmem    = (w_dec.cls == C_SW);
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = (w_dec.cls == C_IALU) | (w_dec.cls == C_LW);
        m2reg = (w_dec.cls == C_LW);
      end
      default: ;
    endcase
    // Reset abandons any access in flight: no strobe may leak out while clr is high.
    if (clr) begin
      mem_req  = 1'b0;
      wmem     = 1'b0;
      wpc      = 1'b0;
      wir      = 1'b0;
      wreg     = 1'b0;
      pcsource = RST_PC_SEL;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cyc_cnt <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state != S_IF) && (w_next == S_IF))
        r_instret <= r_instret + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-accurate bench for mc_ctrl: a per-cycle expected control word is
// queued as stimulus is driven and compared (under a care mask) when sampled.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int W = 22;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       wmem;
    logic       iord;
    logic       wpc;
    logic       wir;
    logic       wreg;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
  } obs_t;

  logic        clk, clr, zero, mem_rdy;
  logic [5:0]  op, func;
  logic        mem_req, wmem, iord, wpc, wir, wreg, regrt, m2reg, jal, sext, shift;
  logic [1:0]  alusrcb, pcsource;
  logic [3:0]  aluc;
  logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instret;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  obs_t e, m;

  mc_ctrl #(.RST_PC_SEL(2'b00)) dut (
    .clk(clk), .clr(clr), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .wmem(wmem), .iord(iord), .wpc(wpc), .wir(wir),
    .wreg(wreg), .regrt(regrt), .m2reg(m2reg), .jal(jal), .sext(sext),
    .shift(shift), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
    .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instret(instret)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic clear_exp();
    e = '0;
    m = '0;
  endtask

  task automatic want_state(input logic [2:0] s);
    e.state = s; m.state = '1;
  endtask

  task automatic want_en(input logic mr, input logic wm, input logic wp,
                         input logic wi, input logic wr);
    e.mem_req = mr; e.wmem = wm; e.wpc = wp; e.wir = wi; e.wreg = wr;
    m.mem_req = 1'b1; m.wmem = 1'b1; m.wpc = 1'b1; m.wir = 1'b1; m.wreg = 1'b1;
  endtask

  // driver: drive inputs, queue expectation, sample on the falling edge
  task automatic step(input logic rdy, input logic z, input string tag);
    logic [W-1:0] obs, ex, mk;
    mem_rdy = rdy;
    zero    = z;
    exp_q.push_back(e & m);
    msk_q.push_back(m);
    @(negedge clk);
    obs = {state, mem_req, wmem, iord, wpc, wir, wreg, regrt, m2reg, jal,
           sext, shift, alusrcb, aluc, pcsource};
    ex = exp_q.pop_front();
    mk = msk_q.pop_front();
    check_val(tag, 32'(obs & mk), 32'(ex));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    for (int i = 0; i < n; i++) begin
      clear_exp();
      want_en(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e.pcsource = 2'b00; m.pcsource = '1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset");
    end
    clr = 1'b0;
  endtask

  // reference model of one instruction, cycle by cycle; mem_abort>=0 stops inside MEM
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int if_st, input int mem_st, input int mem_abort);
    logic ralu, shf, ialu, addi, lw, sw, beq, bne, jj, jl, jr, ill, taken, rdy;
    logic [3:0] ac;
    ralu = 0; shf = 0; ialu = 0; addi = 0; lw = 0; sw = 0; beq = 0; bne = 0;
    jj = 0; jl = 0; jr = 0; ill = 0; ac = ALU_ADD;
    if (o == 6'b000000) begin
      case (f)
        6'b100000: begin ralu = 1; ac = ALU_ADD; end
        6'b100010: begin ralu = 1; ac = ALU_SUB; end
        6'b100100: begin ralu = 1; ac = ALU_AND; end
        6'b100101: begin ralu = 1; ac = ALU_OR;  end
        6'b100110: begin ralu = 1; ac = ALU_XOR; end
        6'b000000: begin ralu = 1; ac = ALU_SLL; shf = 1; end
        6'b000010: begin ralu = 1; ac = ALU_SRL; shf = 1; end
        6'b000011: begin ralu = 1; ac = ALU_SRA; shf = 1; end
        6'b001000: jr = 1;
        default:   ill = 1;
      endcase
    end else begin
      case (o)
        6'b001000: begin ialu = 1; addi = 1; ac = ALU_ADD; end
        6'b001100: begin ialu = 1; ac = ALU_AND; end
        6'b001101: begin ialu = 1; ac = ALU_OR;  end
        6'b001110: begin ialu = 1; ac = ALU_XOR; end
        6'b001111: begin ialu = 1; ac = ALU_LUI; end
        6'b100011: lw = 1;
        6'b101011: sw = 1;
        6'b000100: beq = 1;
        6'b000101: bne = 1;
        6'b000010: jj = 1;
        6'b000011: jl = 1;
        default:   ill = 1;
      endcase
    end
    op = o; func = f;

    for (int i = 0; i <= if_st; i++) begin
      rdy = (i == if_st);
      clear_exp(); want_state(3'd0);
      want_en(1'b1, 1'b0, rdy, rdy, 1'b0);
      e.iord = 0; m.iord = 1; e.alusrcb = 2'b01; m.alusrcb = '1;
      e.aluc = ALU_ADD; m.aluc = '1; e.pcsource = 2'b00; m.pcsource = '1;
      step(rdy, 1'($urandom_range(0, 1)), "IF");
    end

    clear_exp(); want_state(3'd1);
    want_en(1'b0, 1'b0, jj | jl | jr, 1'b0, jl);
    e.alusrcb = 2'b11; m.alusrcb = '1; e.sext = 1; m.sext = 1; e.jal = jl; m.jal = 1;
    if (jj | jl | jr) begin e.pcsource = jr ? 2'b10 : 2'b11; m.pcsource = '1; end
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "ID");
    if (jj | jl | jr | ill) return;

    taken = (beq & z) | (bne & ~z);
    clear_exp(); want_state(3'd2);
    want_en(1'b0, 1'b0, taken, 1'b0, 1'b0);
    if (ralu) begin
      e.alusrcb = 2'b00; m.alusrcb = '1; e.aluc = ac; m.aluc = '1; e.shift = shf; m.shift = 1;
    end
    if (ialu) begin
      e.alusrcb = 2'b10; m.alusrcb = '1; e.aluc = ac; m.aluc = '1; e.sext = addi; m.sext = 1;
    end
    if (lw | sw) begin
      e.alusrcb = 2'b10; m.alusrcb = '1; e.aluc = ALU_ADD; m.aluc = '1; e.sext = 1; m.sext = 1;
    end
    if (beq | bne) begin
      e.aluc = ALU_SUB; m.aluc = '1;
      if (taken) begin e.pcsource = 2'b01; m.pcsource = '1; end
    end
    step(1'($urandom_range(0, 1)), z, "EXE");
    if (beq | bne) return;

    if (lw | sw) begin
      for (int i = 0; i <= mem_st; i++) begin
        if (i == mem_abort) return;
        rdy = (i == mem_st);
        clear_exp(); want_state(3'd3);
        want_en(1'b1, sw, 1'b0, 1'b0, 1'b0);
        e.iord = 1; m.iord = 1;
        step(rdy, 1'($urandom_range(0, 1)), "MEM");
      end
      if (sw) return;
    end

    clear_exp(); want_state(3'd4);
    want_en(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e.regrt = ialu | lw; m.regrt = 1; e.m2reg = lw; m.m2reg = 1; e.jal = 0; m.jal = 1;
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "WB");
  endtask

  logic [11:0] tbl [20];

  initial begin
    clr = 1'b1; op = '0; func = '0; zero = 1'b0; mem_rdy = 1'b0;
    tbl = '{ {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
             {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
             {6'b000000, 6'b000010}, {6'b000000, 6'b000011}, {6'b000000, 6'b001000},
             {6'b001000, 6'b010101}, {6'b001100, 6'b000000}, {6'b001101, 6'b111000},
             {6'b001110, 6'b000001}, {6'b001111, 6'b000000}, {6'b100011, 6'b000000},
             {6'b101011, 6'b000000}, {6'b000100, 6'b000000}, {6'b000101, 6'b000000},
             {6'b000010, 6'b000000}, {6'b000011, 6'b000000} };

    do_reset(2);

    // every table entry once, no stalls
    for (int i = 0; i < 20; i++)
      run_instr(tbl[i][11:6], tbl[i][5:0], 1'b1, 0, 0, -1);

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);   // add
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, -1);   // lw, 3 MEM wait cycles
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 1, -1);   // sw, IF and MEM waits
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, -1);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, -1);   // beq not taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, -1);   // bne not taken
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, -1);   // bne taken
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, -1);   // jal
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, -1);   // illegal opcode
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, -1);   // illegal func

    // reset while lw waits in MEM, then a clean instruction from IF
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 5, 1);
    do_reset(2);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);

    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 19);
      run_instr(tbl[k][11:6], tbl[k][5:0], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

`ifdef MC_CTRL_PERF_EN
    do_reset(1);
    for (int i = 0; i < 10; i++)
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    check_val("instret", instret, 32'd10);
    check_val("cyc_cnt", cyc_cnt, 32'd40);
`endif

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the 32-bit CPU.
- Sequences the shared datapath (PC, IR, A/B, ALU-out and MDR dffe32 registers, register file, unified memory) through the IF/ID/EXE/MEM/WB states.
- Drives every register enable and mux select, and waits on a memory ready handshake.
- Sits between the instruction register and the datapath; it is the only source of the `e` enables on the dffe32 pipeline registers.

Parameters:
- RST_PC_SEL, 2'b00: pcsource value driven while clr is high.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  synchronous reset, active-high
- op  in  6  IR[31:26] opcode
- func  in  6  IR[5:0] function field
- zero  in  1  ALU zero flag, combinational, valid in EXE
- mem_rdy  in  1  memory completed access this cycle
- mem_req  out  1  memory access request
- wmem  out  1  memory write strobe (qualifies mem_req)
- iord  out  1  0 = address from PC, 1 = address from ALU-out
- wpc  out  1  PC register enable
- wir  out  1  IR register enable
- wreg  out  1  register file write enable
- regrt  out  1  destination is rt (1) or rd (0)
- m2reg  out  1  writeback source is MDR (1) or ALU-out (0)
- jal  out  1  force destination reg 31, data PC+4
- sext  out  1  sign-extend immediate
- shift  out  1  ALU A operand = sa
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- aluc  out  4  ALU op code
- pcsource  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
- state  out  3  current state, for debug

Behaviour:
- Reset: while clr=1, all enables/strobes (mem_req, wmem, wpc, wir, wreg) are 0 and pcsource=RST_PC_SEL. On the clr edge, state becomes IF.
- Reset mid-operation: any in-flight access is abandoned, nothing is written, and the next state is IF.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 are unreachable and recover to IF.
- IF:
  - mem_req=1, iord=0, alusrcb=01, aluc=ADD, pcsource=00.
  - Holds while mem_rdy=0.
  - On mem_rdy=1: wir=1 and wpc=1 in the same cycle, then go to ID.
- ID:
  - Computes branch target (alusrcb=11, sext=1).
  - j: wpc=1, pcsource=11, then IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, then IF.
  - jr: wpc=1, pcsource=10, then IF.
  - All others go to EXE.
- EXE:
  - R-type: alusrcb=00, aluc from func; shift=1 for sll/srl/sra; then WB.
  - addi/andi/ori/xori/lui: alusrcb=10; sext=1 only for addi; then WB.
  - lw/sw: aluc=ADD, alusrcb=10, sext=1, then MEM.
  - beq/bne: aluc=SUB. wpc=1 with pcsource=01 iff (beq & zero) | (bne & ~zero). Then IF.
- MEM:
  - mem_req=1, iord=1; wmem=1 for sw.
  - Holds while mem_rdy=0.
  - On mem_rdy=1: lw goes to WB, sw goes to IF.
- WB:
  - wreg=1; regrt=1 for I-type; m2reg=1 for lw. Then IF.
- Latency in cycles with mem_rdy always 1: j/jal/jr 2, beq/bne 3, R-type/ALU-imm/sw 4, lw 5. Each mem_rdy=0 cycle adds one.
- Illegal op/func: treated as a no-op that completes in ID with no writes, then IF.
- Outputs are combinational from state, op, func, zero and mem_rdy. state is registered.
- mem_rdy asserted outside IF/MEM is ignored.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined: adds outputs cyc_cnt[31:0] and instret[31:0].
  - cyc_cnt increments every non-reset cycle.
  - instret increments on every transition into IF from another state.
  - Both clear on clr and wrap modulo 2^32.
- When not defined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding constants
  - opcode and func constants (R=000000, addi=001000, andi=001100, ori=001101, xori=001110, lui=001111, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011; func add/sub/and/or/xor/sll/srl/sra/jr)
  - aluc codes (ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA)
- One combinational sub-module, mc_decode: op/func → instruction class and aluc. The FSM lives in mc_ctrl.

Test Plan:
- clr=1 for 2 cycles mid-MEM of a lw → mem_req, wreg, wpc, wir all 0; state=0 one cycle after clr falls.
- add (op=0, func=100000), mem_rdy=1 → states 0,1,2,4,0; wir/wpc pulse in cycle 0; wreg=1, regrt=0 in cycle 3.
- lw with mem_rdy low for 3 cycles in MEM → MEM held 4 cycles, then WB with m2reg=1; total 8 cycles.
- beq with zero=1 → wpc=1, pcsource=01 in EXE. With zero=0 → wpc=0. bne gives the inverse.
- jal → 2 cycles, wreg=1, jal=1, pcsource=11 in ID. Illegal op 111111 → 2 cycles, no writes.
- With MC_CTRL_PERF_EN, 10 R-type instructions after reset → instret=10, cyc_cnt=40.
